// File: rtl/mem_port_arbiter_if.sv
// Requester and Memoria signal bundle for the shared memory port arbiter.
// The arbiter connects through slave; the environment side uses master.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_gnt;
   logic              ls_rvalid;
   logic [DATA_W-1:0] ls_rdata;

   logic [ADDR_W-1:0] mem_address;
   logic              mem_write;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;

   logic              busy;

   modport slave (
      input  if_req, if_addr,
      input  ls_req, ls_we, ls_addr, ls_wdata,
      input  mem_data_out,
      output if_gnt, if_rvalid, if_rdata,
      output ls_gnt, ls_rvalid, ls_rdata,
      output mem_address, mem_write, mem_data_in,
      output busy
   );

   modport master (
      output if_req, if_addr,
      output ls_req, ls_we, ls_addr, ls_wdata,
      output mem_data_out,
      input  if_gnt, if_rvalid, if_rdata,
      input  ls_gnt, ls_rvalid, ls_rdata,
      input  mem_address, mem_write, mem_data_in,
      input  busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and load/store onto one Memoria port.
// LS has fixed priority; a starvation counter forces an IF grant.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clock,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);
   localparam int WCW = (RD_LAT + 1 > 1) ? $clog2(RD_LAT + 1) : 1;
   localparam int SCW = (STARVE_MAX + 1 > 1) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [WCW-1:0] WLAST = WCW'(RD_LAT - 1);
   localparam logic [SCW-1:0] SMAX  = SCW'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t            state_q, state_d;
   logic              ls_own_q, ls_own_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [WCW-1:0]    wcnt_q, wcnt_d;
   logic [SCW-1:0]    starve_q, starve_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
   logic              if_rv_q, if_rv_d;
   logic              ls_rv_q, ls_rv_d;

   logic ls_wins;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         ls_own_q   <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wcnt_q     <= '0;
         starve_q   <= '0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
         if_rv_q    <= 1'b0;
         ls_rv_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ls_own_q   <= ls_own_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wcnt_q     <= wcnt_d;
         starve_q   <= starve_d;
         if_rdata_q <= if_rdata_d;
         ls_rdata_q <= ls_rdata_d;
         if_rv_q    <= if_rv_d;
         ls_rv_q    <= ls_rv_d;
      end
   end

   // LS loses a tie only once IF has been passed over STARVE_MAX times
   assign ls_wins = bus.ls_req && (!bus.if_req || (starve_q != SMAX));

   always_comb begin
      state_d    = state_q;
      ls_own_d   = ls_own_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wcnt_d     = wcnt_q;
      starve_d   = starve_q;
      if_rdata_d = if_rdata_q;
      ls_rdata_d = ls_rdata_q;
      if_rv_d    = 1'b0;
      ls_rv_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ls_wins) begin
               state_d  = ISSUE;
               ls_own_d = 1'b1;
               we_d     = bus.ls_we;
               addr_d   = bus.ls_addr;
               wdata_d  = bus.ls_wdata;
               if (bus.if_req) begin
                  starve_d = SCW'(starve_q + 1'b1);
               end
            end else if (bus.if_req) begin
               state_d  = ISSUE;
               ls_own_d = 1'b0;
               we_d     = 1'b0;
               addr_d   = bus.if_addr;
               starve_d = '0;
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT;
               wcnt_d  = WLAST;
            end
         end
         WAIT: begin
            if (wcnt_q == '0) begin
               state_d = IDLE;
               if (ls_own_q) begin
                  ls_rdata_d = bus.mem_data_out;
                  ls_rv_d    = 1'b1;
               end else begin
                  if_rdata_d = bus.mem_data_out;
                  if_rv_d    = 1'b1;
               end
            end else begin
               wcnt_d = WCW'(wcnt_q - 1'b1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.if_gnt      = (state_q == ISSUE) && !ls_own_q;
   assign bus.ls_gnt      = (state_q == ISSUE) && ls_own_q;
   assign bus.mem_write   = (state_q == ISSUE) && we_q;
   assign bus.mem_address = addr_q;
   assign bus.mem_data_in = wdata_q;
   assign bus.if_rvalid   = if_rv_q;
   assign bus.ls_rvalid   = ls_rv_q;
   assign bus.if_rdata    = if_rdata_q;
   assign bus.ls_rdata    = ls_rdata_q;
   assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with RD_LAT=2, STARVE_MAX=2.
// Directed traffic; a negedge monitor pops expected grants/data.
module tb_mem_port_arbiter;
   logic clk;
   logic rst;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .RD_LAT(2),
      .STARVE_MAX(2)
   ) dut (
      .clock(clk),
      .reset(rst),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem_arr [256];
   bit          gnt_q [$];
   logic [31:0] if_exp [$];
   logic [31:0] ls_exp [$];
   logic [63:0] wr_q [$];

   assign bus.mem_data_out = mem_arr[bus.mem_address[9:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic unexp(input string name);
      checks++;
      failures++;
      $display("FAIL %s act=1 exp=0", name);
   endtask

   // Monitor: also acts as the Memoria write port
   initial begin
      bit          g;
      logic [31:0] d;
      logic [63:0] w;
      for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
      mem_arr[8'h00] = 32'h1357_9BDF;
      mem_arr[8'h10] = 32'hDEAD_BEEF;
      mem_arr[8'h20] = 32'hCAFE_F00D;
      forever begin
         @(negedge clk);
         if (bus.if_gnt || bus.ls_gnt) begin
            chk("one_gnt", 64'(bus.if_gnt & bus.ls_gnt), 64'd0);
            if (gnt_q.size() == 0) unexp("unexpected_gnt");
            else begin
               g = gnt_q.pop_front();
               chk("gnt_order_ls", 64'(bus.ls_gnt), 64'(g));
            end
         end
         if (bus.if_rvalid) begin
            chk("one_rvalid", 64'(bus.ls_rvalid), 64'd0);
            if (if_exp.size() == 0) unexp("unexpected_if_rvalid");
            else begin
               d = if_exp.pop_front();
               chk("if_rdata", 64'(bus.if_rdata), 64'(d));
            end
         end
         if (bus.ls_rvalid) begin
            if (ls_exp.size() == 0) unexp("unexpected_ls_rvalid");
            else begin
               d = ls_exp.pop_front();
               chk("ls_rdata", 64'(bus.ls_rdata), 64'(d));
            end
         end
         if (bus.mem_write) begin
            if (wr_q.size() == 0) unexp("unexpected_mem_write");
            else begin
               w = wr_q.pop_front();
               chk("mem_write_addr_data",
                   {bus.mem_address, bus.mem_data_in}, w);
            end
            mem_arr[bus.mem_address[9:2]] = bus.mem_data_in;
         end
      end
   end

   task automatic wait_gnt(input bit ls, input string name);
      bit got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ls ? bus.ls_gnt : bus.if_gnt) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         unexp({name, "_gnt_timeout"});
      end
   endtask

   task automatic do_if(input logic [31:0] a);
      bus.if_req  = 1'b1;
      bus.if_addr = a;
      wait_gnt(1'b0, "if");
      bus.if_req  = 1'b0;
   endtask

   task automatic do_ls(input logic we, input logic [31:0] a,
                        input logic [31:0] wd);
      bus.ls_req   = 1'b1;
      bus.ls_we    = we;
      bus.ls_addr  = a;
      bus.ls_wdata = wd;
      wait_gnt(1'b1, "ls");
      bus.ls_req   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int ng;
      rst          = 1'b1;
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.ls_req   = 1'b0;
      bus.ls_we    = 1'b0;
      bus.ls_addr  = '0;
      bus.ls_wdata = '0;
      idle(2);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_addr", 64'(bus.mem_address), 64'd0);
      chk("reset_rdata", {bus.if_rdata, bus.ls_rdata}, 64'd0);
      rst = 1'b0;
      idle(1);

      // 1: single fetch, cycle-exact latency
      gnt_q.push_back(1'b0);
      if_exp.push_back(32'hDEAD_BEEF);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h40;
      @(negedge clk);
      chk("t1_gnt_c1", 64'(bus.if_gnt), 64'd1);
      chk("t1_addr_c1", 64'(bus.mem_address), 64'h40);
      bus.if_req = 1'b0;
      @(negedge clk);
      chk("t1_addr_c2", 64'(bus.mem_address), 64'h40);
      @(negedge clk);
      chk("t1_addr_c3", 64'(bus.mem_address), 64'h40);
      chk("t1_rv_c3", 64'(bus.if_rvalid), 64'd0);
      @(negedge clk);
      chk("t1_rv_c4", 64'(bus.if_rvalid), 64'd1);
      chk("t1_rdata_c4", 64'(bus.if_rdata), 64'hDEAD_BEEF);
      idle(2);

      // 2: simultaneous requests, LS first
      gnt_q.push_back(1'b1);
      gnt_q.push_back(1'b0);
      ls_exp.push_back(32'hCAFE_F00D);
      if_exp.push_back(32'hDEAD_BEEF);
      fork
         do_ls(1'b0, 32'h80, 32'h0);
         do_if(32'h40);
      join
      idle(8);

      // 3: both held high, IF forced after two LS wins
      for (int i = 0; i < 2; i++) begin
         gnt_q.push_back(1'b1);
         gnt_q.push_back(1'b1);
         gnt_q.push_back(1'b0);
         ls_exp.push_back(32'hCAFE_F00D);
         ls_exp.push_back(32'hCAFE_F00D);
         if_exp.push_back(32'hDEAD_BEEF);
      end
      bus.ls_req  = 1'b1;
      bus.ls_we   = 1'b0;
      bus.ls_addr = 32'h80;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h40;
      ng = 0;
      for (int i = 0; i < 200 && ng < 6; i++) begin
         @(negedge clk);
         if (bus.if_gnt || bus.ls_gnt) ng++;
      end
      bus.ls_req = 1'b0;
      bus.if_req = 1'b0;
      chk("t3_grant_count", 64'(ng), 64'd6);
      idle(8);

      // 4: store then read back
      gnt_q.push_back(1'b1);
      wr_q.push_back({32'h100, 32'h1234_5678});
      do_ls(1'b1, 32'h100, 32'h1234_5678);
      @(negedge clk);
      chk("t4_busy_after", 64'(bus.busy), 64'd0);
      chk("t4_wr_after", 64'(bus.mem_write), 64'd0);
      gnt_q.push_back(1'b1);
      ls_exp.push_back(32'h1234_5678);
      do_ls(1'b0, 32'h100, 32'h0);
      idle(6);

      // 5: reset in the middle of a load
      gnt_q.push_back(1'b1);
      do_ls(1'b0, 32'h80, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t5_busy", 64'(bus.busy), 64'd0);
      chk("t5_mem", {bus.mem_address, bus.mem_data_in}, 64'd0);
      chk("t5_ctl", 64'({bus.mem_write, bus.if_gnt, bus.ls_gnt,
                         bus.if_rvalid, bus.ls_rvalid}), 64'd0);
      chk("t5_rdata", {bus.if_rdata, bus.ls_rdata}, 64'd0);
      idle(3);
      rst = 1'b0;
      idle(1);
      gnt_q.push_back(1'b0);
      if_exp.push_back(32'h1357_9BDF);
      do_if(32'h0);
      idle(6);

      // 6: IF request withdrawn before it could be granted
      gnt_q.push_back(1'b1);
      ls_exp.push_back(32'hCAFE_F00D);
      do_ls(1'b0, 32'h80, 32'h0);
      @(negedge clk);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h200;
      @(negedge clk);
      bus.if_req  = 1'b0;
      idle(8);
      chk("t6_busy", 64'(bus.busy), 64'd0);

      chk("end_gnt_q", 64'(gnt_q.size()), 64'd0);
      chk("end_if_exp", 64'(if_exp.size()), 64'd0);
      chk("end_ls_exp", 64'(ls_exp.size()), 64'd0);
      chk("end_wr_q", 64'(wr_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
